// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, operand width and the E-stage result-mux select.
package mdu_pkg;

  localparam int unsigned MD_W            = 32;
  localparam int unsigned MD_CNT_W        = 8;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Selects which unit drives the E/M result register.
  typedef enum logic {
    ESEL_ALU = 1'b0,
    ESEL_MDU = 1'b1
  } e_res_sel_e;

  function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v);
    return v[MD_W-1] ? (~v + {{(MD_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/mdu_md_calc.sv
// Combinational result generator: produces the 64-bit {hi,lo} value that the
// shadow register captures when a mult/div op is accepted.
module md_calc
  import mdu_pkg::*;
(
  input  logic [MD_W-1:0]   i_a,
  input  logic [MD_W-1:0]   i_b,
  input  logic [3:0]        i_mdctrl,
  input  logic [MD_W-1:0]   i_hi,
  input  logic [MD_W-1:0]   i_lo,
  output logic [2*MD_W-1:0] o_shadow
);

  logic [2*MD_W-1:0] w_prod_u;
  logic [2*MD_W-1:0] w_prod_s;
  logic [MD_W-1:0]   w_abs_a;
  logic [MD_W-1:0]   w_abs_b;
  logic [MD_W-1:0]   w_sdiv_b;
  logic [MD_W-1:0]   w_udiv_b;
  logic [MD_W-1:0]   w_mq;
  logic [MD_W-1:0]   w_mr;
  logic [MD_W-1:0]   w_sq;
  logic [MD_W-1:0]   w_sr;
  logic [MD_W-1:0]   w_uq;
  logic [MD_W-1:0]   w_ur;
  logic              w_b_zero;

  assign w_prod_u = {{MD_W{1'b0}}, i_a} * {{MD_W{1'b0}}, i_b};
  assign w_prod_s = {{MD_W{i_a[MD_W-1]}}, i_a} * {{MD_W{i_b[MD_W-1]}}, i_b};

  assign w_b_zero = (i_b == {MD_W{1'b0}});
  assign w_abs_a  = md_abs(i_a);
  assign w_abs_b  = md_abs(i_b);

  // Divisors are forced to 1 on b=0 so the dividers never see zero; the
  // result is discarded in that case anyway.
  assign w_sdiv_b = w_b_zero ? {{(MD_W-1){1'b0}}, 1'b1} : w_abs_b;
  assign w_udiv_b = w_b_zero ? {{(MD_W-1){1'b0}}, 1'b1} : i_b;

  // Signed divide on magnitudes; this also yields 0x80000000 rem 0 for the
  // most-negative / -1 case without special handling.
  assign w_mq = w_abs_a / w_sdiv_b;
  assign w_mr = w_abs_a % w_sdiv_b;
  assign w_sq = (i_a[MD_W-1] ^ i_b[MD_W-1]) ? (~w_mq + {{(MD_W-1){1'b0}}, 1'b1}) : w_mq;
  assign w_sr = i_a[MD_W-1] ? (~w_mr + {{(MD_W-1){1'b0}}, 1'b1}) : w_mr;

  assign w_uq = i_a / w_udiv_b;
  assign w_ur = i_a % w_udiv_b;

  // Op select; divide-by-zero and non-arithmetic ops hold current HI/LO.
  always_comb begin
    o_shadow = {i_hi, i_lo};
    case (i_mdctrl)
      MD_MULT:  o_shadow = w_prod_s;
      MD_MULTU: o_shadow = w_prod_u;
      MD_DIV: begin
        if (w_b_zero) o_shadow = {i_hi, i_lo};
        else          o_shadow = {w_sr, w_sq};
      end
      MD_DIVU: begin
        if (w_b_zero) o_shadow = {i_hi, i_lo};
        else          o_shadow = {w_ur, w_uq};
      end
      default:  o_shadow = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter and commits the shadowed result when the counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  input  logic [3:0]      mdctrl,
  input  logic            start,
  output logic            busy,
  output logic [MD_W-1:0] mdo
);

  localparam logic [MD_CNT_W-1:0] CNT_ZERO = {MD_CNT_W{1'b0}};
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

  logic [MD_W-1:0]     r_hi;
  logic [MD_W-1:0]     r_lo;
  logic [MD_W-1:0]     r_shadow_hi;
  logic [MD_W-1:0]     r_shadow_lo;
  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_busy;

  logic [2*MD_W-1:0]   w_shadow_nxt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  logic                w_accept;
  logic                w_load_shadow;
  logic                w_commit;

  md_calc u_calc (
    .i_a      (a),
    .i_b      (b),
    .i_mdctrl (mdctrl),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_shadow (w_shadow_nxt)
  );

  assign w_accept = start & ~r_busy;
  assign busy     = r_busy;

  // Counter next-state: load on accepted mult/div, count down while busy.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_load_shadow = 1'b0;
    w_commit      = 1'b0;
    if (w_accept) begin
      case (mdctrl)
        MD_MULT, MD_MULTU: begin
          w_cnt_nxt     = MD_CNT_W'(MULT_CYCLES);
          w_load_shadow = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          w_cnt_nxt     = MD_CNT_W'(DIV_CYCLES);
          w_load_shadow = 1'b1;
        end
        default: w_cnt_nxt = r_cnt;
      endcase
    end else if (r_cnt != CNT_ZERO) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
      w_commit  = (r_cnt == CNT_ONE);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Latency counter and registered busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= CNT_ZERO;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != CNT_ZERO);
    end
  end

  // Shadow result captured from the operands present at the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow_hi <= {MD_W{1'b0}};
      r_shadow_lo <= {MD_W{1'b0}};
    end else if (w_load_shadow) begin
      r_shadow_hi <= w_shadow_nxt[2*MD_W-1:MD_W];
      r_shadow_lo <= w_shadow_nxt[MD_W-1:0];
    end
  end

  // Architectural HI/LO: commit at counter expiry, or direct MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= {MD_W{1'b0}};
      r_lo <= {MD_W{1'b0}};
    end else if (w_commit) begin
      r_hi <= r_shadow_hi;
      r_lo <= r_shadow_lo;
    end else if (w_accept && (mdctrl == MD_MTHI)) begin
      r_hi <= a;
    end else if (w_accept && (mdctrl == MD_MTLO)) begin
      r_lo <= a;
    end
  end

  // mfhi/mflo read port; pre-op values remain visible while busy.
  always_comb begin
    mdo = {MD_W{1'b0}};
    case (mdctrl)
      MD_MFHI: mdo = r_hi;
      MD_MFLO: mdo = r_lo;
      default: mdo = {MD_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO and busy length are queued at issue
// and checked when busy drops.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  mdctrl;
  logic        start;
  logic        busy;
  logic [31:0] mdo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .mdctrl (mdctrl),
    .start  (start),
    .busy   (busy),
    .mdo    (mdo)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mdctrl = MD_MFHI;
    #1 hi = mdo;
    mdctrl = MD_MFLO;
    #1 lo = mdo;
    mdctrl = MD_NONE;
  endtask

  // Called at a negedge; returns at the negedge after the launching posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    mdctrl = op;
    a      = aa;
    b      = bb;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mdctrl = MD_NONE;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc,
                        input string name);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = cyc; e.name = name;
    sb.push_back(e);
    issue(op, aa, bb);
  endtask

  task automatic wait_commit();
    exp_t        e;
    int          cnt;
    logic [31:0] hi, lo;
    e   = sb.pop_front();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (cnt == 0) begin
        read_hilo(hi, lo);
        n_cmp++;
        if (hi !== m_hi || lo !== m_lo) begin
          n_err++;
          $display("FAIL %s_old_while_busy: got hi=%h lo=%h want hi=%h lo=%h", e.name, hi, lo, m_hi, m_lo);
        end
      end
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== e.cyc) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", e.name, cnt, e.cyc);
    end
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== e.hi || lo !== e.lo) begin
      n_err++;
      $display("FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", e.name, hi, lo, e.hi, e.lo);
    end
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b0; start = 1'b0; mdctrl = MD_NONE; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    launch(MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult");
    wait_commit();
    launch(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, "multu");
    wait_commit();
  endtask

  task automatic test_div();
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
    wait_commit();
    launch(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
    wait_commit();
    launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, "div_ovf");
    wait_commit();
  endtask

  task automatic test_divzero();
    logic [31:0] hi, lo;
    issue(MD_MTHI, 32'h11, 32'd0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL mthi_busy: got %b want 0", busy);
    end
    issue(MD_MTLO, 32'h22, 32'd0);
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_err++;
      $display("FAIL mt_hilo: got hi=%h lo=%h want 11/22", hi, lo);
    end
    m_hi = 32'h11;
    m_lo = 32'h22;
    @(negedge clk);
    launch(MD_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 10, "div_zero");
    wait_commit();
    launch(MD_DIVU, 32'd9, 32'd0, 32'h11, 32'h22, 10, "divu_zero");
    wait_commit();
  endtask

  task automatic test_start_while_busy();
    launch(MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 2, "busy_ignore");
    @(negedge clk);
    issue(MD_MTLO, 32'h55, 32'd0);
    issue(MD_MULT, 32'd7, 32'd7);
    wait_commit();
  endtask

  task automatic test_random();
    logic [3:0]         op;
    logic [31:0]        ra, rb, ehi, elo;
    logic signed [31:0] sa, sbv;
    longint             sp;
    longint unsigned    up;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      if (i == 5) rb = 32'd13;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      sa  = ra;
      sbv = rb;
      case (op)
        MD_MULT: begin
          sp = longint'(sa) * longint'(sbv);
          {ehi, elo} = sp;
        end
        MD_MULTU: begin
          up = longint'(ra) * longint'(rb);
          {ehi, elo} = up;
        end
        MD_DIV: begin
          elo = sa / sbv;
          ehi = sa % sbv;
        end
        default: begin
          elo = ra / rb;
          ehi = ra % rb;
        end
      endcase
      launch(op, ra, rb, ehi, elo, (op == MD_MULT || op == MD_MULTU) ? 5 : 10, "random");
      wait_commit();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi, lo;
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre_busy: got %b want 1", busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_busy_async: got %b want 0", busy);
    end
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_busy_after: cycle %0d got %b want 0", i, busy);
      end
    end
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_no_commit: got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk);
    launch(MD_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5, "post_reset");
    wait_commit();
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    mdctrl = MD_NONE;
    a      = 32'd0;
    b      = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_start_while_busy();
    test_random();
    test_reset_mid_op();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
